shifter_operand_stage: RTL and testbench
========================================

// Module: shifter_operand_stage
// PURPOSE
// - Producer side of the barrel-shifter interface: decodes the ARMv4 data-processing operand2 field into the final operand and shifter carry-out.
// - Covers immediate-rotate, immediate-shift and register-shift forms, including every encoding the 5-bit barrel shifter cannot express.
// - Sits between decode and ALU. valid/ready in and out. Register-specified shifts stall while Rs is read from the register file.
// PARAMETERS
// - RS_LAT  1  cycles from o_rs_req to valid i_rs_data; legal range 1..3
// PORTS
// - i_clk       in   1   clock, all state on rising edge
// - i_rst       in   1   synchronous reset, active-high
// - i_valid     in   1   instruction presented
// - o_ready     out  1   stage can accept this cycle
// - i_instr     in   32  instruction; uses [25] I, [11:0] operand2
// - i_rm        in   32  Rm value; ignored when I=1
// - i_cflag     in   1   current CPSR C
// - o_rs_req    out  1   Rs read request, 1-cycle pulse
// - o_rs_addr   out  4   Rs index = i_instr[11:8], held from request until data is sampled
// - i_rs_data   in   32  Rs value, valid RS_LAT cycles after o_rs_req
// - o_valid     out  1   result valid
// - i_ready     in   1   consumer accepts the result
// - o_op2       out  32  shifter operand
// - o_carry     out  1   shifter carry-out
// BEHAVIOUR
// - Reset values: o_valid=0, o_op2=0, o_carry=0, o_rs_req=0, o_rs_addr=0, FSM=IDLE, latency counter=0.
// - Accept occurs when i_valid && o_ready. o_ready = (state==IDLE) && (!o_valid || i_ready).
// - On accept, capture i_instr, i_rm and i_cflag.
// - FSM states: IDLE, RS_REQ, RS_WAIT.
//   - IDLE -> RS_REQ: accept with I=0 and instr[4]=1.
//   - RS_REQ: o_rs_req=1 for this cycle only; load counter with RS_LAT; -> RS_WAIT.
//   - RS_WAIT: decrement counter; when counter==1, sample i_rs_data[7:0] as amt, load the output register, -> IDLE.
// - Latency from accept at T:
//   - Immediate forms: o_valid at T+1.
//   - Register shift: o_valid at T+2+RS_LAT.
// - Output register holds o_op2/o_carry stable while o_valid && !i_ready. o_valid clears on handshake unless a new result is loaded in the same cycle (back-to-back allowed).
// - I=1 (immediate rotate): op2 = ror(imm8, 2*rot).
//   - carry = i_cflag if rot==0, else op2[31].
// - I=0, bit4=0 (immediate shift): amt=[11:7], type=[6:5] (LSL/LSR/ASR/ROR).
//   - amt!=0: standard shift; carry = last bit shifted out.
//   - amt==0 special cases:
//     - LSL: op2=rm, carry=cflag.
//     - LSR: op2=0, carry=rm[31].
//     - ASR: op2={32{rm[31]}}, carry=rm[31].
//     - ROR: RRX, op2={cflag,rm[31:1]}, carry=rm[0].
// - I=0, bit4=1 (register shift): amt=Rs[7:0]; Rs[31:8] ignored.
//   - amt==0: op2=rm, carry=cflag (all types).
//   - LSL: 1..31 normal; 32 -> 0, C=rm[0]; >32 -> 0, C=0.
//   - LSR: 1..31 normal; 32 -> 0, C=rm[31]; >32 -> 0, C=0.
//   - ASR: >=32 -> {32{rm[31]}}, C=rm[31].
//   - ROR: amt[4:0]==0 -> op2=rm, C=rm[31]; else ror by amt[4:0].
// - Reset mid-operation: transaction discarded; no o_valid and no further o_rs_req.
// - Inputs are ignored while o_ready=0.
// CONFIGURATION
// - SHIFTER_OPERAND_FAST_RS_EN defined:
//   - o_rs_addr = i_instr[11:8] combinationally; o_rs_req = i_valid && register-shift form.
//   - i_rs_data is valid in the accept cycle; every form has o_valid at T+1.
//   - RS_REQ/RS_WAIT are removed; RS_LAT is ignored.
// - Macro undefined: multi-cycle FSM as described above.
// TESTING
// - I=1, imm8=0xFF, rot=4 -> o_op2=0xFF000000, o_carry=1, o_valid at T+1.
// - LSR #0, rm=0x80000001 -> 0x00000000, C=1.
//   ROR #0, cflag=1, rm=0x00000003 -> 0x80000001, C=1.
// - Register LSL, rm=1, RS_LAT=1:
//   - Rs=32 -> 0, C=1; Rs=33 -> 0, C=0.
//   - Rs=0x100 -> rm, C=cflag.
//   - o_rs_req at T+1 only; o_valid at T+3.
// - Register ROR Rs=32, rm=0x80000000 -> 0x80000000, C=1.
//   Register ASR Rs=200 -> 0xFFFFFFFF, C=1.
// - Hold i_ready=0 for 4 cycles -> o_op2/o_carry stable, o_ready=0.
//   Release -> new instruction accepted in the same cycle.
// - Assert i_rst while in RS_WAIT -> o_valid stays 0; o_rs_req=0 from the next cycle.

Source files
------------

// File: rtl/shifter_operand_stage.sv
// ARMv4 operand2 decode stage: immediate-rotate, immediate-shift and register-shift forms into op2/carry.
// Build option SHIFTER_OPERAND_FAST_RS_EN: Rs is read combinationally in the accept cycle (no RS_REQ/RS_WAIT).
`timescale 1ns/1ps
module shifter_operand_stage #(
  parameter int unsigned RS_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rm,
  input  logic        i_cflag,
  output logic        o_rs_req,
  output logic [3:0]  o_rs_addr,
  input  logic [31:0] i_rs_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_op2,
  output logic        o_carry
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid is never withdrawn and the payload holds steady until that transfer.

  // Returns {carry, op2}; ramt is only consulted for the register-shift form (op[4]=1).
  function automatic logic [32:0] shift_operand(
    input logic        ibit,
    input logic [11:0] op,
    input logic [31:0] rm,
    input logic        cin,
    input logic [7:0]  ramt
  );
    logic [31:0] res;
    logic        cy;
    logic [4:0]  rot;
    logic [4:0]  a;
    logic [4:0]  li;
    logic [4:0]  ri;
    logic [31:0] ror_v;
    logic        is_reg;
    logic        zero;
    logic        big;
    logic        is32;
    res = rm;
    cy  = cin;
    if (ibit) begin
      rot = {op[11:8], 1'b0};
      res = 32'({24'd0, op[7:0], 24'd0, op[7:0]} >> rot);
      cy  = (rot == 5'd0) ? cin : res[31];
    end else begin
      is_reg = op[4];
      a      = is_reg ? ramt[4:0] : op[11:7];
      zero   = is_reg ? (ramt == 8'd0) : (op[11:7] == 5'd0);
      big    = is_reg && (ramt[7:5] != 3'd0);
      is32   = (ramt == 8'd32);
      li     = 5'(6'd32 - {1'b0, a});
      ri     = a - 5'd1;
      ror_v  = 32'({rm, rm} >> a);
      case (op[6:5])
        2'b00: begin
          if (!zero) begin
            if (big) begin
              res = '0;
              cy  = is32 & rm[0];
            end else begin
              res = rm << a;
              cy  = rm[li];
            end
          end
        end
        2'b01: begin
          // Immediate LSR #0 encodes a shift by 32.
          if (zero) begin
            if (!is_reg) begin
              res = '0;
              cy  = rm[31];
            end
          end else if (big) begin
            res = '0;
            cy  = is32 & rm[31];
          end else begin
            res = rm >> a;
            cy  = rm[ri];
          end
        end
        2'b10: begin
          if (!(zero && is_reg)) begin
            if (zero || big) begin
              res = {32{rm[31]}};
              cy  = rm[31];
            end else begin
              res = 32'($signed(rm) >>> a);
              cy  = rm[ri];
            end
          end
        end
        default: begin
          // Immediate ROR #0 is RRX; register ROR by a nonzero multiple of 32 leaves rm intact.
          if (zero) begin
            if (!is_reg) begin
              res = {cin, rm[31:1]};
              cy  = rm[0];
            end
          end else if (a == 5'd0) begin
            res = rm;
            cy  = rm[31];
          end else begin
            res = ror_v;
            cy  = rm[ri];
          end
        end
      endcase
    end
    return {cy, res};
  endfunction

  logic        ready;
  logic        accept;
  logic        is_reg_in;
  logic        load;
  logic [32:0] shifted;
  logic        valid_q, valid_d;
  logic [31:0] op2_q, op2_d;
  logic        carry_q, carry_d;
  logic        unused_bits;

  assign is_reg_in   = !i_instr[25] && i_instr[4];
  assign accept      = i_valid && ready;
  assign o_ready     = ready;
  assign unused_bits = ^{i_instr[31:26], i_instr[24:12], i_rs_data[31:8]};

`ifdef SHIFTER_OPERAND_FAST_RS_EN
  logic [1:0] unused_rs_lat;

  assign unused_rs_lat = 2'(RS_LAT);
  assign ready         = !valid_q || i_ready;
  assign load          = accept;
  assign o_rs_req      = i_valid && is_reg_in;
  assign o_rs_addr     = i_instr[11:8];
  assign shifted       = shift_operand(i_instr[25], i_instr[11:0], i_rm, i_cflag, i_rs_data[7:0]);
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RS_REQ  = 2'd1,
    RS_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  rs_addr_q;
  logic [11:0] instr_q;
  logic [31:0] rm_q;
  logic        c_q;
  logic        use_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rs_addr_q <= '0;
      instr_q   <= '0;
      rm_q      <= '0;
      c_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        instr_q <= i_instr[11:0];
        rm_q    <= i_rm;
        c_q     <= i_cflag;
        if (is_reg_in) rs_addr_q <= i_instr[11:8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    use_q   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_reg_in) state_d = RS_REQ;
          else           load    = 1'b1;
        end
      end
      RS_REQ: begin
        cnt_d   = 2'(RS_LAT);
        state_d = RS_WAIT;
      end
      RS_WAIT: begin
        use_q = 1'b1;
        if (cnt_q == 2'd1) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE) && (!valid_q || i_ready);
  assign o_rs_req  = (state_q == RS_REQ);
  assign o_rs_addr = rs_addr_q;
  assign shifted   = use_q ? shift_operand(1'b0, instr_q, rm_q, c_q, i_rs_data[7:0])
                           : shift_operand(i_instr[25], i_instr[11:0], i_rm, i_cflag, 8'd0);
`endif

  // A load in the handshake cycle keeps o_valid high, so results can stream back-to-back.
  always_comb begin
    valid_d = valid_q;
    op2_d   = op2_q;
    carry_d = carry_q;
    if (load) begin
      valid_d = 1'b1;
      op2_d   = shifted[31:0];
      carry_d = shifted[32];
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      op2_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op2_q   <= op2_d;
      carry_q <= carry_d;
    end
  end

  assign o_valid = valid_q;
  assign o_op2   = op2_q;
  assign o_carry = carry_q;

endmodule

// File: tb/tb_shifter_operand_stage.sv
// Bench for shifter_operand_stage: directed spec cases plus random traffic against a bit-serial shift model.
`timescale 1ns/1ps
module tb_shifter_operand_stage;
  localparam int unsigned RS_LAT = 1;
  localparam int N_RAND = 300;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_valid, o_ready, i_cflag, o_rs_req, o_valid, i_ready, o_carry;
  logic [31:0] i_instr, i_rm, i_rs_data, o_op2;
  logic [3:0]  o_rs_addr;

  shifter_operand_stage #(.RS_LAT(RS_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_rm(i_rm), .i_cflag(i_cflag),
    .o_rs_req(o_rs_req), .o_rs_addr(o_rs_addr), .i_rs_data(i_rs_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_op2(o_op2), .o_carry(o_carry)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [31:0] cur_rs   = '0;
  logic [3:0]  cur_addr = '0;
  bit          rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: applies the shift one bit at a time; {carry, op2}.
  function automatic logic [32:0] ref_model(input logic [31:0] instr, input logic [31:0] rm,
                                            input logic c, input logic [31:0] rs);
    logic [31:0] x;
    logic        cy;
    int          n;
    x  = rm;
    cy = c;
    if (instr[25]) begin
      x = {24'd0, instr[7:0]};
      n = 2 * int'(instr[11:8]);
      for (int k = 0; k < n; k++) x = {x[0], x[31:1]};
      cy = (n == 0) ? c : x[31];
      return {cy, x};
    end
    if (instr[4]) begin
      n = int'(rs[7:0]);
    end else begin
      n = int'(instr[11:7]);
      if (n == 0) begin
        case (instr[6:5])
          2'b01, 2'b10: n = 32;
          2'b11: return {rm[0], c, rm[31:1]};
          default: n = 0;
        endcase
      end
    end
    for (int k = 0; k < n; k++) begin
      case (instr[6:5])
        2'b00: begin cy = x[31]; x = {x[30:0], 1'b0};  end
        2'b01: begin cy = x[0];  x = {1'b0, x[31:1]};  end
        2'b10: begin cy = x[0];  x = {x[31], x[31:1]}; end
        default: begin cy = x[0]; x = {x[0], x[31:1]}; end
      endcase
    end
    return {cy, x};
  endfunction

  // driver: present one instruction, push its expected result at the accepting edge
  task automatic issue(input logic [31:0] instr, input logic [31:0] rm, input logic c,
                       input logic [31:0] rs);
    int waited;
    waited  = 0;
    i_valid = 1'b1;
    i_instr = instr;
    i_rm    = rm;
    i_cflag = c;
    @(negedge clk);
    while (!o_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!o_ready) begin
      check("accept_timeout", o_ready, 1);
    end else begin
      if (!instr[25] && instr[4]) begin
        cur_rs   = rs;
        cur_addr = instr[11:8];
      end
      exp_q.push_back(ref_model(instr, rm, c, rs));
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_instr = $urandom;
    i_rm    = $urandom;
    i_cflag = 1'($urandom_range(0, 1));
  endtask

  task automatic reg_timing(input string tag);
    check({tag, "_req_t1"}, o_rs_req, 1);
    check({tag, "_valid_t1"}, o_valid, 0);
    for (int k = 0; k < int'(RS_LAT); k++) begin
      @(posedge clk); #1;
      check({tag, "_req_pulse"}, o_rs_req, 0);
      check({tag, "_valid_early"}, o_valid, 0);
    end
    @(posedge clk); #1;
    check({tag, "_valid_lat"}, o_valid, 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor / scoreboard
  logic [32:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", o_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("op2", o_op2, mon_e[31:0]);
          check("carry", o_carry, mon_e[32]);
        end
      end
    end
  end

  // register-file responder: data valid RS_LAT cycles after the request, random otherwise
  initial begin
    i_rs_data = $urandom;
    forever begin
      @(negedge clk);
      if (!rst && o_rs_req) begin
        check("rs_addr_req", o_rs_addr, cur_addr);
        repeat (RS_LAT) @(posedge clk);
        #1 i_rs_data = cur_rs;
        check("rs_addr_hold", o_rs_addr, cur_addr);
        @(posedge clk);
        #1 i_rs_data = $urandom;
      end
    end
  end

  // consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  logic [31:0] r_instr, r_rm, r_rs, tmp;
  logic        r_c;
  logic [32:0] exp_a;
  int          waited;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_rm = '0; i_cflag = 1'b0; i_ready = 1'b1;
    step(3);
    check("rst_valid", o_valid, 0);
    check("rst_op2", o_op2, 0);
    check("rst_carry", o_carry, 0);
    check("rst_rs_req", o_rs_req, 0);
    check("rst_rs_addr", o_rs_addr, 0);
    check("rst_ready", o_ready, 1);
    rst = 1'b0;
    step(1);

    // immediate forms: result one cycle after accept
    issue(32'h020004FF, 32'h12345678, 1'b0, 0);
    check("imm_rot_valid_t1", o_valid, 1);
    issue(32'h00000020, 32'h80000001, 1'b0, 0);
    check("lsr0_valid_t1", o_valid, 1);
    issue(32'h00000060, 32'h00000003, 1'b1, 0);
    check("rrx_valid_t1", o_valid, 1);

    // register forms
    issue(32'h00000210, 32'h00000001, 1'b0, 32);
    reg_timing("lsl32");
    issue(32'h00000210, 32'h00000001, 1'b0, 33);
    reg_timing("lsl33");
    issue(32'h00000210, 32'h00000001, 1'b1, 32'h100);
    reg_timing("lsl256");
    issue(32'h00000370, 32'h80000000, 1'b0, 32);
    reg_timing("ror32");
    issue(32'h00000450, 32'h80000000, 1'b0, 200);
    reg_timing("asr200");
    step(2);

    // hold under backpressure, then accept in the release cycle
    i_ready = 1'b0;
    exp_a = ref_model(32'h02000A37, 32'h0, 1'b0, 0);
    issue(32'h02000A37, 32'h0, 1'b0, 0);
    check("hold_valid_t1", o_valid, 1);
    i_valid = 1'b1; i_instr = 32'h000000C0; i_rm = 32'hF0F0F0F0; i_cflag = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("hold_valid", o_valid, 1);
      check("hold_op2", o_op2, exp_a[31:0]);
      check("hold_carry", o_carry, exp_a[32]);
      check("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    #1;
    check("release_ready", o_ready, 1);
    issue(32'h000000C0, 32'hF0F0F0F0, 1'b1, 0);
    check("release_valid", o_valid, 1);
    step(2);

    // reset while waiting for Rs
    issue(32'h00000450, 32'h80000000, 1'b0, 200);
    step(1);
    rst = 1'b1;
    exp_q.delete();
    step(1);
    check("midrst_valid", o_valid, 0);
    check("midrst_req", o_rs_req, 0);
    rst = 1'b0;
    repeat (4) begin
      step(1);
      check("postrst_valid", o_valid, 0);
      check("postrst_req", o_rs_req, 0);
    end

    // random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      r_instr = $urandom;
      case ($urandom_range(0, 2))
        0:       r_instr[25] = 1'b1;
        1:       begin r_instr[25] = 1'b0; r_instr[4] = 1'b0; end
        default: begin r_instr[25] = 1'b0; r_instr[4] = 1'b1; end
      endcase
      case ($urandom_range(0, 3))
        0:       r_rm = $urandom;
        1:       r_rm = 32'h80000001;
        2:       r_rm = 32'hFFFFFFFF ^ 32'($urandom_range(0, 1));
        default: r_rm = 32'd1 << $urandom_range(0, 31);
      endcase
      tmp = $urandom;
      case ($urandom_range(0, 4))
        0:       r_rs = 32'($urandom_range(0, 40));
        1:       r_rs = (tmp & 32'hFFFFFF00) | 32'd32;
        2:       r_rs = tmp & 32'hFFFFFF00;
        3:       r_rs = tmp;
        default: r_rs = 32'($urandom_range(0, 255)) | (32'd1 << $urandom_range(8, 31));
      endcase
      r_c = 1'($urandom_range(0, 1));
      issue(r_instr, r_rm, r_c, r_rs);
      step($urandom_range(0, 2));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      step(1);
      waited++;
    end
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
